// File: rtl/mac_accum.sv
`default_nettype none
// ============================================================================
// mac_accum : sums vec_len signed 32-bit MAC terms into a 40-bit accumulator,
//             then rounds, shifts and saturates the sum to a signed 16-bit result.
// Revision  : 1.0
// ============================================================================
module mac_accum #(
    parameter int SHIFT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  vec_len,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] mac_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_sat,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam logic signed [40:0] HALF = 41'sd1 <<< (SHIFT - 1);

    logic [1:0]  state_q, state_d;
    logic [39:0] acc_q,   acc_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic [7:0]  len_q,   len_d;
    logic [15:0] data_q,  data_d;
    logic        sat_q,   sat_d;

    logic [7:0]         cnt_inc;
    logic signed [40:0] rnd_sum;
    logic signed [40:0] rnd_r;

    // One guard bit above the accumulator keeps the rounding add from overflowing.
    always_comb begin
        rnd_sum = $signed({acc_q[39], acc_q}) + HALF;
        rnd_r   = rnd_sum >>> SHIFT;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        data_d  = data_q;
        sat_d   = sat_q;
        cnt_inc = cnt_q + 8'd1;

        case (state_q)
            ST_IDLE: begin
                if (start && (vec_len != 8'd0)) begin
                    len_d   = vec_len;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_d = acc_q + {{8{mac_out[31]}}, mac_out};
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = ST_ROUND;
                    end
                end
            end
            ST_ROUND: begin
                if (rnd_r > 41'sd32767) begin
                    data_d = 16'h7FFF;
                    sat_d  = 1'b1;
                end else if (rnd_r < -41'sd32768) begin
                    data_d = 16'h8000;
                    sat_d  = 1'b1;
                end else begin
                    data_d = rnd_r[15:0];
                    sat_d  = 1'b0;
                end
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = data_q;
    assign out_sat   = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_accum.sv
`default_nettype none
// ============================================================================
// tb_mac_accum : scoreboard bench for mac_accum (SHIFT = 15).
// Revision     : 1.0
// ============================================================================
module tb_mac_accum;

    localparam int SHIFT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  vec_len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mac_out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;
    logic        busy;

    int          pass_cnt = 0;
    int          chk_cnt  = 0;
    logic [16:0] exp_q[$];
    logic [31:0] terms[$];
    bit          vpat[$];

    mac_accum #(.SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vec_len   (vec_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mac_out   (mac_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: full-precision sum, round half up, arithmetic shift, clip.
    function automatic logic [16:0] model();
        longint s;
        longint r;
        s = 0;
        foreach (terms[i]) s += longint'($signed(terms[i]));
        r = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        if (r > 32767)       return {1'b1, 16'h7FFF};
        else if (r < -32768) return {1'b1, 16'h8000};
        else                 return {1'b0, r[15:0]};
    endfunction

    task automatic send_vec(input int len, input logic [16:0] exp);
        int idx;
        int p;
        int guard;
        exp_q.push_back(exp);
        start   = 1'b1;
        vec_len = len[7:0];
        tick();
        start = 1'b0;
        idx   = 0;
        p     = 0;
        guard = 0;
        while (idx < len) begin
            mac_out  = terms[idx];
            in_valid = (p < vpat.size()) ? vpat[p] : 1'b1;
            p++;
            if (idx == 0 || idx == len - 1) check("accum_ready", in_ready, 1);
            tick();
            if (in_valid) idx++;
            guard++;
            if (guard > 600) begin
                check("beat_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
        check("round_ready", in_ready, 0);
        check("round_valid", out_valid, 0);
        tick();
        check("latency_valid", out_valid, 1);
    endtask

    task automatic collect(input int hold);
        int          n;
        logic [16:0] e;
        logic [15:0] d0;
        logic        s0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) check("out_timeout", 0, 1);
        e = exp_q.pop_front();
        check("out_data", out_data, e[15:0]);
        check("out_sat", out_sat, e[16]);
        d0 = out_data;
        s0 = out_sat;
        for (int i = 0; i < hold; i++) begin
            start   = 1'b1;
            vec_len = 8'd3;
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, d0);
            check("hold_sat", out_sat, s0);
            check("hold_ready", in_ready, 0);
            check("hold_busy", busy, 1);
        end
        start     = (hold > 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("idle_valid", out_valid, 0);
        check("idle_busy", busy, 0);
        tick();
        check("start_ignored", busy, 0);
    endtask

    initial begin
        logic [31:0] rv;
        int          len;
        rst_n     = 1'b0;
        start     = 1'b0;
        vec_len   = 8'd0;
        in_valid  = 1'b0;
        mac_out   = 32'd0;
        out_ready = 1'b0;
        repeat (3) tick();
        check("rst_ready", in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 16'h0000);
        check("rst_sat", out_sat, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        start   = 1'b1;
        vec_len = 8'd0;
        tick();
        start = 1'b0;
        check("len0_ignored", busy, 0);

        terms = '{32'h0000_8000, 32'h0000_8000, 32'h0000_8000};
        send_vec(3, {1'b0, 16'h0003});
        collect(0);

        terms = '{32'h0000_4000};
        send_vec(1, {1'b0, 16'h0001});
        collect(0);
        terms = '{32'h0000_3FFF};
        send_vec(1, {1'b0, 16'h0000});
        collect(0);
        terms = '{32'hFFFF_C000};
        send_vec(1, {1'b0, 16'h0000});
        collect(0);

        terms = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
        send_vec(4, {1'b1, 16'h7FFF});
        collect(0);
        terms = '{32'h8000_0000, 32'h8000_0000};
        send_vec(2, {1'b1, 16'h8000});
        collect(0);

        terms = '{32'h0012_3456, 32'hFFF0_0000, 32'h0100_0000, 32'h0000_8000};
        send_vec(4, model());
        collect(0);
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        send_vec(4, model());
        collect(0);
        vpat.delete();

        // Longest vector of most-negative terms: exercises the no-wrap headroom.
        terms.delete();
        repeat (255) terms.push_back(32'h8000_0000);
        send_vec(255, model());
        collect(0);

        for (int v = 0; v < 6; v++) begin
            terms.delete();
            len = $urandom_range(1, 30);
            for (int k = 0; k < len; k++) begin
                rv = $urandom;
                if (v % 2 == 0) rv = {{12{rv[19]}}, rv[19:0]};
                terms.push_back(rv);
            end
            vpat.delete();
            for (int k = 0; k < 2 * len; k++) vpat.push_back(bit'($urandom_range(0, 1)));
            send_vec(len, model());
            collect(0);
        end
        vpat.delete();

        terms = '{32'h0123_4567};
        send_vec(1, model());
        collect(5);

        terms   = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000};
        start   = 1'b1;
        vec_len = 8'd4;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mac_out  = terms[k];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_ready", in_ready, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 16'h0000);
        check("midrst_sat", out_sat, 0);
        check("midrst_busy", busy, 0);
        repeat (3) tick();
        check("midrst_no_out", out_valid, 0);
        terms = '{32'h0000_8000};
        send_vec(1, {1'b0, 16'h0001});
        collect(0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_accum.md
MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 Parameter: SHIFT, 15, right-shift applied to the accumulated sum before output; legal range 1..24.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin a new vector; sampled only in IDLE.
REQ-005 vec_len  input  8  number of terms in the vector (1..255); sampled with start.
REQ-006 in_valid  input  1  mac_out carries a valid term this cycle.
REQ-007 in_ready  output  1  block accepts a term this cycle.
REQ-008 mac_out  input  32  signed two's-complement term from the upstream MAC unit.
REQ-009 out_valid  output  1  out_data/out_sat hold a result.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_data  output  16  signed rounded, saturated result.
REQ-012 out_sat  output  1  result was clipped during saturation.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, ACCUM, ROUND and OUT.
REQ-015 IDLE: in_ready=0, out_valid=0; start=1 with vec_len!=0 -> latch vec_len, clear the 40-bit accumulator and term counter, go to ACCUM.
REQ-016 start with vec_len==0 SHALL be ignored (remain in IDLE); start in any non-IDLE state SHALL be ignored.
REQ-017 ACCUM: in_ready=1; a beat SHALL be accepted only on an edge where in_valid=1 and in_ready=1; cycles with in_valid=0 SHALL change nothing.
REQ-018 Each accepted beat SHALL add sign-extend(mac_out) to the 40-bit signed accumulator and increment the counter.
REQ-019 The accumulator SHALL NOT wrap: 255 terms x 32-bit always fit in 40 bits.
REQ-020 On the edge accepting beat number vec_len, the next state SHALL be ROUND; in_ready SHALL be 0 from that edge on.
REQ-021 ROUND: compute r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic, half rounds toward +infinity).
REQ-022 Saturation: r > 32767 -> out_data=0x7FFF, out_sat=1; r < -32768 -> out_data=0x8000, out_sat=1; otherwise out_data=r[15:0], out_sat=0.
REQ-023 out_data, out_sat and out_valid=1 SHALL be registered on the single edge leaving ROUND; state becomes OUT (latency: out_valid high one edge after the last beat is accepted).
REQ-024 OUT: out_valid=1; out_data and out_sat SHALL stay stable until the edge where out_ready=1, which SHALL return the FSM to IDLE with out_valid=0.
REQ-025 A start in the same cycle as the out_ready handshake SHALL be ignored (the FSM is not in IDLE yet).
REQ-026 busy SHALL be 1 in ACCUM, ROUND and OUT.

Reset
REQ-027 On an edge with rst_n=0: state=IDLE, accumulator=0, counter=0, in_ready=0, out_valid=0, out_data=0x0000, out_sat=0, busy=0.
REQ-028 A reset during ACCUM, ROUND or OUT SHALL discard the partial result; no out_valid SHALL follow.
REQ-029 Reset SHALL take priority over every other input on the same edge.

Verification
REQ-030 SHIFT=15, vec_len=3, three terms 0x00008000 -> out_data=0x0003, out_sat=0, out_valid one edge after the third beat.
REQ-031 Rounding: vec_len=1, term 0x00004000 -> 0x0001; term 0x00003FFF -> 0x0000; term 0xFFFFC000 -> 0x0000.
REQ-032 Saturation: vec_len=4, terms 0x40000000 -> 0x7FFF, out_sat=1; vec_len=2, terms 0x80000000 -> 0x8000, out_sat=1.
REQ-033 Input bubbles: vec_len=4, in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 beats accepted, result equals the gap-free result.
REQ-034 Backpressure: out_ready=0 for 5 cycles with start pulsed -> out_valid/out_data stable, in_ready=0, start ignored; out_ready=1 -> IDLE.
REQ-035 Reset mid-vector: rst_n=0 after beat 2 of 4 -> all outputs are 0 at the next edge; then start with vec_len=1, term 0x00008000 -> out_data=0x0001.
